main_mem_ctrl: RTL and testbench

MAIN_MEM_CTRL -- requirements
Module: main_mem_ctrl

---
 rtl/mem_pkg.sv | 22 ++
 rtl/main_mem_ctrl_if.sv | 33 +++
 rtl/mem_array.sv | 27 ++
 rtl/main_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_main_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the main memory controller.
package mem_pkg;

    typedef logic [127:0] line_t;
    typedef logic [31:0]  addr_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT,
        RESPOND,
        DRAIN
    } state_t;

    localparam int LINES_DEF  = 1024;
    localparam int RD_LAT_DEF = 4;
    localparam int WR_LAT_DEF = 4;

    // Latency counter width: latencies go up to 15, so the counter holds up to 14.
    localparam int CNT_W = 4;

endpackage

// File: rtl/main_mem_ctrl_if.sv
// L2-to-main-memory line request bus. The master is the L2 side, the slave is the controller.
interface main_mem_ctrl_if;
    import mem_pkg::*;

    logic  mem_read_req;
    logic  mem_write_req;
    addr_t mem_addr;
    line_t mem_write_data;
    line_t mem_read_data;
    logic  mem_ready;
    logic  busy;

    modport master (
        output mem_read_req,
        output mem_write_req,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data,
        input  mem_ready,
        input  busy
    );

    modport slave (
        input  mem_read_req,
        input  mem_write_req,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data,
        output mem_ready,
        output busy
    );

endinterface

// File: rtl/mem_array.sv
// Line storage: one synchronous write port, one combinational read port.
// Contents are not touched by reset, so they survive a controller reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int LINES = LINES_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(LINES)-1:0] waddr,
    input  line_t                    wdata,
    input  logic [$clog2(LINES)-1:0] raddr,
    output line_t                    rdata
);

    line_t mem [LINES] = '{default: '0};

    // Commit a line on the write strobe.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Main memory controller: serves one line read or writeback at a time with
// fixed, parameterised latencies. A request is captured in IDLE, counted down
// in WAIT, acknowledged with a one-cycle mem_ready in RESPOND and then the
// controller sits in DRAIN until the served request line is released.
module main_mem_ctrl
    import mem_pkg::*;
#(
    parameter int LINES  = LINES_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int WR_LAT = WR_LAT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    main_mem_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [CNT_W-1:0] RD_LAT_M1 = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAT_M1 = CNT_W'(WR_LAT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [IDX_W-1:0]   idx_q;
    line_t              wdata_q;
    line_t              rd_data_q;
    line_t              arr_rdata;
    logic               arr_we;
    logic               capture;
    logic               served_req;
    logic               rd_load;

    // Address bits outside the line index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[31:IDX_W+4], bus.mem_addr[3:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes; writes take priority over reads at capture.
    always_comb begin
        state_nxt  = state;
        arr_we     = 1'b0;
        capture    = 1'b0;
        served_req = op_wr ? bus.mem_write_req : bus.mem_read_req;
        case (state)
            IDLE: begin
                if (bus.mem_read_req || bus.mem_write_req) begin
                    capture   = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                arr_we    = op_wr;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!served_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: loaded in CAPTURE, counts down to zero in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == CAPTURE) begin
            cnt <= op_wr ? WR_LAT_M1 : RD_LAT_M1;
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Operation type of the in-flight request; write wins when both are raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr <= 1'b0;
        end else if (capture) begin
            op_wr <= bus.mem_write_req;
        end
    end

    // Request payload snapshot; later bus changes do not disturb the in-flight request.
    always_ff @(posedge clk) begin
        if (capture) begin
            idx_q   <= bus.mem_addr[IDX_W+3:4];
            wdata_q <= bus.mem_write_data;
        end
    end

    // Read data register: loaded on entry to RESPOND of a read, held otherwise.
    assign rd_load = (state == WAIT) && (cnt == '0) && !op_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= arr_rdata;
        end
    end

    mem_array #(
        .LINES (LINES)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (idx_q),
        .rdata (arr_rdata)
    );

    assign bus.mem_ready     = (state == RESPOND);
    assign bus.busy          = (state != IDLE);
    assign bus.mem_read_data = rd_data_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: the driver pushes expected responses
// from a line-array reference model, an independent monitor pops and compares
// them on every mem_ready pulse (data and request-to-ready latency).
module tb_main_mem_ctrl;

    localparam int LINES  = 1024;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 3;

    typedef struct {
        bit           is_wr;
        logic [127:0] data;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;

    main_mem_ctrl_if bus ();

    main_mem_ctrl #(
        .LINES  (LINES),
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t         sb_q[$];
    logic [127:0] ref_mem [LINES];
    logic [127:0] last_rd;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 4) % LINES);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: record the expected response of one transaction.
    task automatic model_push(input bit is_wr, input logic [31:0] addr, input logic [127:0] data);
        exp_t e;
        e.is_wr = is_wr;
        if (is_wr) begin
            e.data = last_rd;
            e.lat  = WR_LAT + 1;
            ref_mem[idx_of(addr)] = data;
        end else begin
            e.data  = ref_mem[idx_of(addr)];
            e.lat   = RD_LAT + 1;
            last_rd = e.data;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: track capture cycle from busy rising, check each ready pulse.
    int   cyc = 0;
    int   cap_cyc = 0;
    logic busy_prev = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) cap_cyc = cyc;
        busy_prev = bus.busy;
        if (bus.mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                check(e.is_wr ? "wr_latency" : "rd_latency", 128'(cyc - cap_cyc), 128'(e.lat));
                check(e.is_wr ? "wr_keeps_rdata" : "rd_data", bus.mem_read_data, e.data);
            end
        end
    end

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no ready in 40 cycles expected ready", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: got busy=1 after 10 cycles expected 0", name);
        end
    endtask

    // One read or write; hold keeps the request high for extra cycles after ready.
    task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [127:0] data, input int hold);
        @(posedge clk); #1;
        bus.mem_addr       = addr;
        bus.mem_write_data = data;
        if (is_wr) bus.mem_write_req = 1'b1;
        else       bus.mem_read_req  = 1'b1;
        model_push(is_wr, addr, data);
        @(posedge clk); #1;
        bus.mem_addr       = $urandom;
        bus.mem_write_data = rand128();
        wait_ready(is_wr ? "wr" : "rd");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_no_ready", 128'(bus.mem_ready), 128'(0));
            check("held_busy", 128'(bus.busy), 128'(1));
        end
        @(posedge clk); #1;
        bus.mem_read_req  = 1'b0;
        bus.mem_write_req = 1'b0;
        wait_idle("txn");
    endtask

    // Read and write raised together: write must be served first.
    task automatic do_both(input logic [31:0] waddr, input logic [127:0] wdata, input logic [31:0] raddr);
        @(posedge clk); #1;
        bus.mem_addr       = waddr;
        bus.mem_write_data = wdata;
        bus.mem_write_req  = 1'b1;
        bus.mem_read_req   = 1'b1;
        model_push(1'b1, waddr, wdata);
        wait_ready("both_wr");
        @(posedge clk); #1;
        bus.mem_write_req = 1'b0;
        bus.mem_addr      = raddr;
        model_push(1'b0, raddr, '0);
        wait_ready("both_rd");
        @(posedge clk); #1;
        bus.mem_read_req = 1'b0;
        wait_idle("both");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  a;
        logic [127:0] d;

        for (int i = 0; i < LINES; i++) ref_mem[i] = '0;
        last_rd            = '0;
        bus.mem_read_req   = 1'b0;
        bus.mem_write_req  = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        rst_n              = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(bus.mem_ready), 128'(0));
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_rdata", bus.mem_read_data, '0);
        rst_n = 1'b1;

        // Write then read within the same line.
        d = 128'hDEADBEEF_00000000_00000000_00000001;
        do_txn(1'b1, 32'h0000_0120, d, 0);
        do_txn(1'b0, 32'h0000_012C, '0, 0);

        // Aliasing: high address bits above the index are ignored.
        do_txn(1'b1, 32'h0000_0040, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        do_txn(1'b0, 32'h0000_4040, '0, 0);

        // Simultaneous requests, same line with different old contents, then different lines.
        do_txn(1'b1, 32'h0000_0300, 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD, 0);
        do_both(32'h0000_0300, 128'hC0DE_C0DE_1234_5678_9ABC_DEF0_0000_0042, 32'h0000_0300);
        do_both(32'h0000_0500, rand128(), 32'h0000_0120);

        // Held read: one pulse only, busy held until release.
        do_txn(1'b0, 32'h0000_0040, '0, 3);

        // Reset in the middle of a write's WAIT phase.
        @(posedge clk); #1;
        bus.mem_addr       = 32'h0000_0200;
        bus.mem_write_data = rand128();
        bus.mem_write_req  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(bus.busy), 128'(0));
        check("midrst_ready", 128'(bus.mem_ready), 128'(0));
        check("midrst_rdata", bus.mem_read_data, '0);
        bus.mem_write_req = 1'b0;
        last_rd = '0;
        @(negedge clk);
        check("midrst_busy_next", 128'(bus.busy), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 128'(bus.busy), 128'(0));
        do_txn(1'b0, 32'h0000_0200, '0, 0);
        do_txn(1'b0, 32'h0000_0120, '0, 0);

        // Randomized traffic over a small aliased line pool.
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 15) << 4) | ($urandom_range(0, 7) << 14) | $urandom_range(0, 15);
            d = rand128();
            if ($urandom_range(0, 5) == 0) begin
                do_both(a, d, ($urandom_range(0, 15) << 4) | ($urandom_range(0, 3) << 14));
            end else begin
                do_txn($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 2));
            end
        end

        repeat (3) @(posedge clk);
        check("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
